// File: rtl/axis_sample_pacer.sv
// Purpose: buffers producer samples in a small FIFO and releases one sample per clk_div-cycle tick onto AXI-Stream.
// Latency: a sample popped on a tick is presented (tvalid=1) on the cycle after the tick; writes become poppable one cycle after acceptance.
// Backpressure: in_ready drops while the FIFO is full; a stalled downstream holds tdata/tvalid and any tick during the stall is discarded.
//
// Ports:
//   clk, rst_n            - single rising-edge clock, asynchronous active-low reset
//   in_valid/in_data      - producer write strobe and signed sample; accepted when in_ready is high
//   in_ready              - FIFO not full
//   m_axis_tdata/tvalid   - paced output sample, held until m_axis_tready
//   m_axis_tready         - downstream ready
//   fifo_level            - current FIFO occupancy (0..fifo_depth)
//   underrun_cnt          - saturating count of IDLE ticks that found the FIFO empty
//
// Build option: define PACER_ZERO_FILL_EN to emit a zero sample on empty-FIFO ticks,
// keeping the downstream sample rate constant. Without it, empty ticks produce no transfer.

module axis_sample_pacer #(
  parameter int inout_width = 16,
  parameter int clk_div     = 100000,
  parameter int fifo_depth  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [inout_width-1:0]        in_data,
  output logic                          in_ready,
  output logic [inout_width-1:0]        m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [$clog2(fifo_depth):0]   fifo_level,
  output logic [15:0]                   underrun_cnt
);

  localparam int CW = $clog2(clk_div);
  localparam int AW = $clog2(fifo_depth);
  localparam int LW = AW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic [15:0]            underrun_q, underrun_d;
  logic [inout_width-1:0] tdata_q, tdata_d;
  state_t                 state_q, state_d;

  // Sample storage carries no reset: an entry is only read after it was written.
  logic [inout_width-1:0] mem_q [fifo_depth];

  logic tick;
  logic empty;
  logic full;
  logic wr_en;
  logic pop;

  // Free-running rate counter: tick is high for exactly one cycle per clk_div cycles.
  assign tick  = (cnt_q == CW'(clk_div - 1));
  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(fifo_depth));
  assign wr_en = in_valid & ~full;
  // Pop decisions use the registered level, so a write lands one cycle before it can be popped.
  assign pop   = (state_q == IDLE) & tick & ~empty;

  assign in_ready      = ~full;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = (state_q == SEND);
  assign fifo_level    = level_q;
  assign underrun_cnt  = underrun_q;

  always_comb begin
    cnt_d      = tick ? '0 : cnt_q + 1'b1;
    // Pointers wrap naturally because fifo_depth is a power of two.
    wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d    = level_q;
    state_d    = state_q;
    tdata_d    = tdata_q;
    underrun_d = underrun_q;

    case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    case (state_q)
      IDLE: begin
        if (tick) begin
          if (!empty) begin
            tdata_d = mem_q[rd_ptr_q];
            state_d = SEND;
          end else begin
            if (underrun_q != 16'hFFFF) begin
              underrun_d = underrun_q + 16'd1;
            end
`ifdef PACER_ZERO_FILL_EN
            tdata_d = '0;
            state_d = SEND;
`endif
          end
        end
      end
      SEND: begin
        // Ticks seen here are dropped; the held sample waits only for tready.
        if (m_axis_tready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      underrun_q <= '0;
      tdata_q    <= '0;
      state_q    <= IDLE;
    end else begin
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      underrun_q <= underrun_d;
      tdata_q    <= tdata_d;
      state_q    <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_axis_sample_pacer.sv
module tb_axis_sample_pacer;

  localparam int W   = 16;
  localparam int DIV = 10;
  localparam int DEP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [2:0]    fifo_level;
  logic [15:0]   underrun_cnt;

  axis_sample_pacer #(
    .inout_width (W),
    .clk_div     (DIV),
    .fifo_depth  (DEP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .fifo_level    (fifo_level),
    .underrun_cnt  (underrun_cnt)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc;

  logic [W-1:0] exp_q[$];
  int           rise_q[$];

  // Rising edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rise_at(input int i);
    return (rise_q.size() > i) ? rise_q[i] : -1;
  endfunction

  // Monitor: samples mid-low-phase, pops the scoreboard on each handshake,
  // and verifies tdata/tvalid hold steady across stalls.
  logic         prev_vld   = 1'b0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] held       = '0;

  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      prev_vld   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (m_axis_tvalid && !prev_vld) rise_q.push_back(cyc);
      if (prev_stall) begin
        check("hold_valid", m_axis_tvalid, 1);
        check("hold_data", m_axis_tdata, held);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_output: got %0d, expected no transfer (cycle %0d)", m_axis_tdata, cyc);
        end else begin
          check("out_data", m_axis_tdata, exp_q.pop_front());
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      held       = m_axis_tdata;
      prev_vld   = m_axis_tvalid;
    end
  end

  // All stimulus tasks are entered and left at a falling edge.
  task automatic do_reset();
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    m_axis_tready = 1'b1;
    exp_q.delete();
    rise_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wr(input logic [W-1:0] v, input bit exp_acc);
    in_valid = 1'b1;
    in_data  = v;
    check("in_ready", in_ready, exp_acc);
    if (exp_acc) exp_q.push_back(v);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      n_vec++;
      n_miss++;
      $display("FAIL wait_cyc: reached cycle %0d, required %0d", cyc, n);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_underrun", underrun_cnt, 0);
    check("rst_tdata", m_axis_tdata, 0);
    @(negedge clk);

    // Two samples paced out on the first two ticks
    do_reset();
    wr(16'd32767, 1);
    wr(16'd0, 1);
    wait_cyc(25);
    check("t1_rises", rise_q.size(), 2);
    check("t1_first_rise", rise_at(0), 10);
    check("t1_second_rise", rise_at(1), 20);
    check("t1_underrun", underrun_cnt, 0);
    check("t1_outstanding", exp_q.size(), 0);

    // Fill to capacity; fifth write refused, order preserved
    do_reset();
    wr(16'd100, 1);
    wr(16'd200, 1);
    wr(16'd300, 1);
    wr(16'd400, 1);
    wr(16'd500, 0);
    check("t2_level_full", fifo_level, 4);
    wait_cyc(45);
    check("t2_rises", rise_q.size(), 4);
    check("t2_level_drained", fifo_level, 0);
    check("t2_outstanding", exp_q.size(), 0);

    // Downstream stall for 25 cycles across two ticks
    do_reset();
    wr(16'h1234, 1);
    wr(16'h5678, 1);
    wait_cyc(5);
    m_axis_tready = 1'b0;
    wait_cyc(21);
    check("t3_vld_mid", m_axis_tvalid, 1);
    check("t3_level_mid", fifo_level, 1);
    check("t3_data_mid", m_axis_tdata, 16'h1234);
    wait_cyc(30);
    check("t3_vld_end", m_axis_tvalid, 1);
    check("t3_level_end", fifo_level, 1);
    check("t3_data_end", m_axis_tdata, 16'h1234);
    check("t3_underrun_stall", underrun_cnt, 0);
    m_axis_tready = 1'b1;
    wait_cyc(45);
    check("t3_second_rise", rise_at(1), 40);
    check("t3_underrun", underrun_cnt, 0);
    check("t3_level", fifo_level, 0);
    check("t3_outstanding", exp_q.size(), 0);

    // Three empty ticks
    do_reset();
`ifdef PACER_ZERO_FILL_EN
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd0);
`endif
    wait_cyc(35);
    check("t4_underrun", underrun_cnt, 3);
`ifdef PACER_ZERO_FILL_EN
    check("t4_rises", rise_q.size(), 3);
`else
    check("t4_rises", rise_q.size(), 0);
`endif
    check("t4_outstanding", exp_q.size(), 0);

    // Asynchronous reset while holding a sample with two buffered
    do_reset();
    m_axis_tready = 1'b0;
    wr(16'd1, 1);
    wr(16'd2, 1);
    wr(16'd3, 1);
    wait_cyc(12);
    check("t5_vld_pre", m_axis_tvalid, 1);
    check("t5_level_pre", fifo_level, 2);
    check("t5_data_pre", m_axis_tdata, 1);
    rst_n = 1'b0;
    #1;
    check("t5_vld_async", m_axis_tvalid, 0);
    check("t5_level_async", fifo_level, 0);
    check("t5_ready_async", in_ready, 1);
    check("t5_data_async", m_axis_tdata, 0);
    do_reset();
    wr(16'd7, 1);
    wait_cyc(15);
    check("t5_rises", rise_q.size(), 1);
    check("t5_rise_after_release", rise_at(0), 10);
    check("t5_outstanding", exp_q.size(), 0);

    // Write and pop in the same cycle at level 2
    do_reset();
    wr(16'd10, 1);
    wr(16'd11, 1);
    wait_cyc(9);
    wr(16'd12, 1);
    check("t6_level_same_cycle", fifo_level, 2);
    wait_cyc(35);
    check("t6_rises", rise_q.size(), 3);
    check("t6_outstanding", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
